// File: rtl/prism_comm_fifo.sv
// PRISM comm front end: TX/RX byte FIFOs around an 8-bit shift engine driven by the
// PRISM shift strobe, so CPU byte traffic is decoupled from engine bit timing.
module prism_comm_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          tx_wr,
  input  logic [7:0]    tx_wdata,
  input  logic          rx_rd,
  output logic [7:0]    rx_rdata,
  output logic [CW-1:0] tx_count,
  output logic [CW-1:0] rx_count,
  output logic [2:0]    flags,
  input  logic [2:0]    flags_clr,
  input  logic          shift_strobe,
  input  logic          shift_dir,
  input  logic          serial_in,
  output logic          serial_out,
  output logic          bit_zero,
  output logic          byte_done
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q, sr_d, shifted;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            dir_q, dir_d;
  logic            done_d, byte_done_q;
  logic [2:0]      flags_q, flags_set;

  logic [7:0]      tx_mem [DEPTH];
  logic [PW-1:0]   tx_rd_ptr, tx_wr_ptr;
  logic [CW-1:0]   tx_cnt_q;
  logic [7:0]      rx_mem [DEPTH];
  logic [PW-1:0]   rx_rd_ptr, rx_wr_ptr;
  logic [CW-1:0]   rx_cnt_q;

  logic tx_empty, tx_full, tx_pop, tx_push;
  logic rx_empty, rx_full, rx_pop, rx_push, rx_push_ok;
  logic underrun_set;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign shifted  = dir_q ? {serial_in, sr_q[7:1]} : {sr_q[6:0], serial_in};

  // Engine next-state: load from TX while idle, shift on strobe, back-to-back reload on byte end
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    dir_d        = dir_q;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    done_d       = 1'b0;
    underrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d    = 3'd0;
        underrun_set = shift_strobe;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          sr_d    = tx_mem[tx_rd_ptr];
          dir_d   = shift_dir;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (shift_strobe) begin
          sr_d      = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_push   = 1'b1;
            done_d    = 1'b1;
            bit_cnt_d = 3'd0;
            if (!tx_empty) begin
              tx_pop = 1'b1;
              sr_d   = tx_mem[tx_rd_ptr];
              dir_d  = shift_dir;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full TX FIFO still accepts a push when the engine pops in the same cycle
  assign tx_push    = tx_wr && (!tx_full || tx_pop);
  assign rx_pop     = rx_rd && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign flags_set  = {underrun_set, rx_push && rx_full && !rx_pop, tx_wr && tx_full && !tx_pop};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= IDLE;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      dir_q       <= 1'b0;
      byte_done_q <= 1'b0;
      flags_q     <= 3'b000;
      tx_rd_ptr   <= '0;
      tx_wr_ptr   <= '0;
      tx_cnt_q    <= '0;
      rx_rd_ptr   <= '0;
      rx_wr_ptr   <= '0;
      rx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      dir_q       <= dir_d;
      byte_done_q <= done_d;
      flags_q     <= (flags_q & ~flags_clr) | flags_set;
      if (tx_push)    tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + PW'(1);
      tx_cnt_q    <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + PW'(1);
      rx_cnt_q    <= rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop);
    end
  end

  // Storage arrays carry no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (tx_push)    tx_mem[tx_wr_ptr] <= tx_wdata;
    if (rx_push_ok) rx_mem[rx_wr_ptr] <= shifted;
  end

  assign rx_rdata   = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
  assign tx_count   = tx_cnt_q;
  assign rx_count   = rx_cnt_q;
  assign flags      = flags_q;
  assign serial_out = (state_q == ACTIVE) ? (dir_q ? sr_q[0] : sr_q[7]) : 1'b1;
  assign bit_zero   = (bit_cnt_q == 3'd0);
  assign byte_done  = byte_done_q;

endmodule

// File: tb/tb_prism_comm_fifo.sv
// Bench for prism_comm_fifo: vector table for single-byte shifts, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_prism_comm_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          tx_wr = 1'b0;
  logic [7:0]    tx_wdata = 8'h00;
  logic          rx_rd = 1'b0;
  logic [7:0]    rx_rdata;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic [2:0]    flags;
  logic [2:0]    flags_clr = 3'b000;
  logic          shift_strobe = 1'b0;
  logic          shift_dir = 1'b0;
  logic          serial_in = 1'b0;
  logic          serial_out;
  logic          bit_zero;
  logic          byte_done;

  int n_chk = 0;
  int n_fail = 0;

  prism_comm_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .tx_count(tx_count), .rx_count(rx_count),
    .flags(flags), .flags_clr(flags_clr), .shift_strobe(shift_strobe),
    .shift_dir(shift_dir), .serial_in(serial_in), .serial_out(serial_out),
    .bit_zero(bit_zero), .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic       wr; logic [7:0] wd; logic rd; logic stb; logic dir; logic sin;
    logic       so; logic bz; logic bd; logic [2:0] txc; logic [2:0] rxc; logic [7:0] rxd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pack(logic so, logic bz, logic bd, logic [2:0] txc,
                                       logic [2:0] rxc, logic [7:0] rxd, logic [2:0] fl);
    return {12'd0, so, bz, bd, txc, rxc, rxd, fl};
  endfunction

  function automatic logic [31:0] dut_out();
    return pack(serial_out, bit_zero, byte_done, tx_count, rx_count, rx_rdata, flags);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mk(input logic wr, input logic [7:0] wd, input logic rd, input logic stb,
                    input logic dir, input logic sin, input logic so, input logic bz,
                    input logic bd, input logic [2:0] txc, input logic [2:0] rxc,
                    input logic [7:0] rxd);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.stb = stb; v.dir = dir; v.sin = sin;
    v.so = so; v.bz = bz; v.bd = bd; v.txc = txc; v.rxc = rxc; v.rxd = rxd;
    vecs.push_back(v);
  endtask

  // One clock edge; single-cycle strobes are dropped afterwards
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0;
    shift_strobe = 1'b0; flags_clr = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      shift_strobe = 1'b1;
      tick();
    end
  endtask

  // Reference model: byte queues plus the byte currently being shifted
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_act, m_dir, m_bd;
  logic [7:0] m_sh;
  int         m_cnt;
  logic [2:0] m_flags;

  function automatic void m_reset();
    m_tx.delete(); m_rx.delete();
    m_act = 1'b0; m_dir = 1'b0; m_bd = 1'b0; m_sh = 8'h00; m_cnt = 0; m_flags = 3'b000;
  endfunction

  function automatic void m_step();
    logic [2:0] set;
    logic       done, rd_ok;
    logic [7:0] got;
    if (rst || flush) begin
      m_reset();
      return;
    end
    set = 3'b000; done = 1'b0; got = 8'h00;
    rd_ok = rx_rd && (m_rx.size() > 0);
    if (!m_act) begin
      if (shift_strobe) set[2] = 1'b1;
      if (m_tx.size() > 0) begin
        m_sh = m_tx.pop_front(); m_dir = shift_dir; m_act = 1'b1; m_cnt = 0;
      end
    end else if (shift_strobe) begin
      m_sh = m_dir ? {serial_in, m_sh[7:1]} : {m_sh[6:0], serial_in};
      m_cnt++;
      if (m_cnt == 8) begin
        done = 1'b1; got = m_sh; m_cnt = 0;
        if (m_tx.size() > 0) begin
          m_sh = m_tx.pop_front(); m_dir = shift_dir;
        end else begin
          m_act = 1'b0;
        end
      end
    end
    if (tx_wr) begin
      if (m_tx.size() < DEPTH) m_tx.push_back(tx_wdata);
      else set[0] = 1'b1;
    end
    if (rd_ok) void'(m_rx.pop_front());
    if (done) begin
      if (m_rx.size() < DEPTH) m_rx.push_back(got);
      else set[1] = 1'b1;
    end
    m_flags = (m_flags & ~flags_clr) | set;
    m_bd = done;
  endfunction

  function automatic logic [31:0] m_out();
    logic so;
    so = m_act ? (m_dir ? m_sh[0] : m_sh[7]) : 1'b1;
    return pack(so, m_cnt == 0, m_bd, 3'(m_tx.size()), 3'(m_rx.size()),
                (m_rx.size() > 0) ? m_rx[0] : 8'h00, m_flags);
  endfunction

  initial begin
    // wr wd rd stb dir sin | so bz bd txc rxc rxd
    mk(1, 8'hA5, 0, 0, 0, 0,  1, 1, 0, 1, 0, 8'h00);
    mk(0, 8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  0, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  1, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  0, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  0, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  1, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  0, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  1, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 0, 0,  1, 1, 1, 0, 1, 8'h00);
    mk(0, 8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 1, 8'h00);
    mk(1, 8'h3C, 1, 0, 1, 0,  1, 1, 0, 1, 0, 8'h00);
    mk(0, 8'h00, 0, 0, 1, 0,  0, 1, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 1,  0, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 1,  1, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 0,  1, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 0,  1, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 0,  1, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 0,  0, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 1,  0, 0, 0, 0, 0, 8'h00);
    mk(0, 8'h00, 0, 1, 1, 1,  1, 1, 1, 0, 1, 8'hC3);
    mk(0, 8'h00, 0, 0, 1, 0,  1, 1, 0, 0, 1, 8'hC3);

    do_reset();
    check("reset_state", dut_out(), pack(1, 1, 0, 0, 0, 8'h00, 3'b000));

    foreach (vecs[i]) begin
      tx_wr = vecs[i].wr; tx_wdata = vecs[i].wd; rx_rd = vecs[i].rd;
      shift_strobe = vecs[i].stb; shift_dir = vecs[i].dir; serial_in = vecs[i].sin;
      tick();
      check($sformatf("vec%0d", i), dut_out(),
            pack(vecs[i].so, vecs[i].bz, vecs[i].bd, vecs[i].txc, vecs[i].rxc, vecs[i].rxd, 3'b000));
    end

    // Back-to-back bytes: the 9th strobe must shift immediately after the reload
    do_reset();
    shift_dir = 1'b0; serial_in = 1'b0;
    tx_wr = 1'b1; tx_wdata = 8'h11; tick();
    check("t3_txc_first", 32'(tx_count), 32'd1);
    tx_wr = 1'b1; tx_wdata = 8'h22; tick();
    check("t3_txc_second", 32'(tx_count), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      shift_strobe = 1'b1; tick();
      check($sformatf("t3_bitzero_%0d", k), 32'(bit_zero), 32'((k % 8) == 0));
      if (k == 8) check("t3_mid", dut_out(), pack(0, 1, 1, 0, 1, 8'h00, 3'b000));
    end
    check("t3_end", dut_out(), pack(1, 1, 1, 0, 2, 8'h00, 3'b000));

    // TX overflow with engine loaded but not shifting; set beats clear
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      tx_wr = 1'b1; tx_wdata = 8'(8'h40 + i); tick();
    end
    check("t4_full", {29'd0, tx_count}, 32'(DEPTH));
    check("t4_ovf", 32'(flags), 32'b001);
    tx_wr = 1'b1; flags_clr = 3'b001; tick();
    check("t4_set_beats_clr", 32'(flags), 32'b001);
    flags_clr = 3'b001; tick();
    check("t4_clr", 32'(flags), 32'b000);

    // RX fill, overflow, then push with simultaneous pop at full
    serial_in = 1'b1;
    strobes(32);
    check("t5_rx_full", dut_out(), pack(1'b0, 1, 1, 0, 4, 8'hFF, 3'b000) | 32'(serial_out) << 19);
    strobes(8);
    check("t5_rx_ovf", 32'({rx_count, flags}), 32'({3'd4, 3'b010}));
    flags_clr = 3'b010; tick();
    tx_wr = 1'b1; tx_wdata = 8'h00; tick();
    tick();
    strobes(7);
    shift_strobe = 1'b1; rx_rd = 1'b1; tick();
    check("t5_push_pop_full", 32'({rx_count, flags, byte_done}), 32'({3'd4, 3'b000, 1'b1}));

    // Flush mid-byte, then strobe while idle
    do_reset();
    tx_wr = 1'b1; tx_wdata = 8'hF0; tick();
    tick();
    strobes(3);
    check("t6_pre_flush_bz", 32'(bit_zero), 32'd0);
    flush = 1'b1; tick();
    check("t6_flush", dut_out(), pack(1, 1, 0, 0, 0, 8'h00, 3'b000));
    shift_strobe = 1'b1; tick();
    check("t6_underrun", 32'(flags), 32'b100);

    // Randomized traffic against the reference model
    rst = 1'b1; m_reset(); tick();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      flush        = ($urandom_range(0, 149) == 0);
      tx_wr        = ($urandom_range(0, 2) == 0);
      tx_wdata     = 8'($urandom);
      rx_rd        = ($urandom_range(0, 3) == 0);
      shift_strobe = ($urandom_range(0, 1) == 0);
      shift_dir    = 1'($urandom);
      serial_in    = 1'($urandom);
      flags_clr    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      m_step();
      @(posedge clk);
      #1;
      check($sformatf("rnd_cycle%0d", c), dut_out(), m_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
